belt_tach: RTL and testbench



---
 rtl/treadmill_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/belt_tach.sv | 155 +++++++++++++++
 tb/tb_belt_tach.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/treadmill_pkg.sv
// rtl/treadmill_pkg.sv - shared speed-bus widths, limits and FSM/measurement types
package treadmill_pkg;

  localparam int SPEED_W   = 8;
  localparam int MAX_SPEED = 199;
  localparam int BCD_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_PUBLISH
  } tach_state_e;

  typedef struct packed {
    logic [SPEED_W-1:0] value;
    logic               over;
  } speed_meas_t;

  // Raw window counts above the displayable range clamp to MAX_SPEED and raise the over flag.
  function automatic speed_meas_t clamp_count(input logic [SPEED_W-1:0] count);
    speed_meas_t m;
    if (count > SPEED_W'(MAX_SPEED)) begin
      m.value = SPEED_W'(MAX_SPEED);
      m.over  = 1'b1;
    end else begin
      m.value = count;
      m.over  = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, 8-bit binary to three BCD digits
// start loads the operand; done pulses 9 cycles after start with the digits stable.
module bin2bcd_seq
  import treadmill_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SPEED_W-1:0] bin,
  output logic               done,
  output logic [BCD_W-1:0]   hundreds,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones
);

  logic [SPEED_W-1:0]   shreg;
  logic [3*BCD_W-1:0]   bcd;
  logic [3*BCD_W-1:0]   bcd_adj;
  logic [3:0]           shift_cnt;
  logic                 busy;

  // Add-3 correction on every digit >= 5, applied before each left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd[d*BCD_W +: BCD_W] >= 4'd5)
        bcd_adj[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg     <= bin;
        bcd       <= '0;
        shift_cnt <= 4'd8;
        busy      <= 1'b1;
      end else if (busy) begin
        bcd       <= {bcd_adj[3*BCD_W-2:0], shreg[SPEED_W-1]};
        shreg     <= {shreg[SPEED_W-2:0], 1'b0};
        shift_cnt <= shift_cnt - 4'd1;
        if (shift_cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign hundreds = bcd[3*BCD_W-1:2*BCD_W];
  assign tens     = bcd[2*BCD_W-1:BCD_W];
  assign ones     = bcd[BCD_W-1:0];

endmodule

// File: rtl/belt_tach.sv
// rtl/belt_tach.sv - belt tachometer: sync/debounce encoder, gate-window count, BCD publish, stall
// One measurement per gate window, published 10 cycles after the window's terminal cycle.
module belt_tach
  import treadmill_pkg::*;
#(
  parameter int GATE_CYCLES   = 5_000_000,
  parameter int DEB_CYCLES    = 16,
  parameter int STALL_WINDOWS = 10
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tach_in,
  input  logic [SPEED_W-1:0] cmd_speed,
  output logic [SPEED_W-1:0] meas_speed,
  output logic [BCD_W-1:0]   speed1,
  output logic [BCD_W-1:0]   speed2,
  output logic [BCD_W-1:0]   speed3,
  output logic               speed_valid,
  output logic               overspeed,
  output logic               stall
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_WINDOWS + 1);

  logic [1:0]         sync_q;
  logic               deb_level;
  logic               deb_level_d;
  logic [DEB_W-1:0]   deb_cnt;
  logic               rise;

  logic [GATE_W-1:0]  gate_cnt;
  logic               window_close;
  logic [SPEED_W-1:0] pulse_cnt;
  logic [SPEED_W-1:0] closing_count;
  speed_meas_t        close_meas;
  speed_meas_t        win_meas;
  logic [STALL_W-1:0] stall_cnt;

  tach_state_e        state;
  logic               bcd_start;
  logic               bcd_done;
  logic [BCD_W-1:0]   bcd_h;
  logic [BCD_W-1:0]   bcd_t;
  logic [BCD_W-1:0]   bcd_o;

  // Any sample that agrees with the filtered level restarts the stability count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync_q      <= {sync_q[0], tach_in};
      deb_level_d <= deb_level;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_level <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign rise         = deb_level & ~deb_level_d;
  assign window_close = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

  // Count including this cycle's edge, so a terminal-cycle edge lands in the closing window.
  always_comb begin
    closing_count = pulse_cnt;
    if (rise && (pulse_cnt != '1))
      closing_count = pulse_cnt + 1'b1;
  end

  assign close_meas = clamp_count(closing_count);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      gate_cnt  <= '0;
      pulse_cnt <= '0;
      win_meas  <= '0;
      stall_cnt <= '0;
    end else if (window_close) begin
      gate_cnt  <= '0;
      pulse_cnt <= '0;
      win_meas  <= close_meas;
      if ((closing_count == '0) && (cmd_speed != '0)) begin
        if (stall_cnt != STALL_W'(STALL_WINDOWS))
          stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end else begin
      gate_cnt  <= gate_cnt + 1'b1;
      pulse_cnt <= closing_count;
    end
  end

  assign bcd_start = window_close && (state == ST_IDLE);

  bin2bcd_seq u_bcd (
    .clk      (CLOCK_50),
    .rst      (reset),
    .start    (bcd_start),
    .bin      (close_meas.value),
    .done     (bcd_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .ones     (bcd_o)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      meas_speed  <= '0;
      speed1      <= '0;
      speed2      <= '0;
      speed3      <= '0;
      speed_valid <= 1'b0;
      overspeed   <= 1'b0;
      stall       <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (window_close)
            state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (bcd_done) begin
            meas_speed  <= win_meas.value;
            overspeed   <= win_meas.over;
            speed1      <= bcd_h;
            speed2      <= bcd_t;
            speed3      <= bcd_o;
            stall       <= (stall_cnt == STALL_W'(STALL_WINDOWS));
            speed_valid <= 1'b1;
            state       <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_belt_tach.sv
// tb/tb_belt_tach.sv - directed table plus randomized waveforms checked against a pulse-run model
module tb_belt_tach;

  localparam int G   = 2400;
  localparam int D   = 4;
  localparam int S   = 3;
  localparam int NW  = 12;
  localparam int NWR = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       tach_in  = 1'b0;
  logic [7:0] cmd_speed = 8'd0;
  logic [7:0] meas_speed;
  logic [3:0] speed1, speed2, speed3;
  logic       speed_valid, overspeed, stall;

  belt_tach #(.GATE_CYCLES(G), .DEB_CYCLES(D), .STALL_WINDOWS(S)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .tach_in     (tach_in),
    .cmd_speed   (cmd_speed),
    .meas_speed  (meas_speed),
    .speed1      (speed1),
    .speed2      (speed2),
    .speed3      (speed3),
    .speed_valid (speed_valid),
    .overspeed   (overspeed),
    .stall       (stall)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int kind;   // 0 none, 1 pulse train, 2 glitch mix, 3 single edge at window offset
    int n;
    int hi;
    int lo;
    int off;
    int cmd;
    int e_meas;
    int e_d1;
    int e_d2;
    int e_d3;
    int e_over;
    int e_stall;
  } vec_t;

  vec_t tbl[NW];
  bit   wave[NW*G];
  int   cmdw[NW];
  int   exp_cnt[NW];
  int   exp_stall[NW];
  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put_high(input int start, input int len);
    for (int i = 0; i < len; i++)
      if (start + i >= 0 && start + i < NW*G) wave[start + i] = 1'b1;
  endtask

  task automatic clear_wave();
    for (int i = 0; i < NW*G; i++) wave[i] = 1'b0;
    for (int w = 0; w < NW; w++) cmdw[w] = 0;
  endtask

  // Every high run of at least D cycles yields one filtered edge 2+D cycles after it starts.
  task automatic model(input int nwin);
    int c, st, len, e, run;
    for (int w = 0; w < NW; w++) exp_cnt[w] = 0;
    c = 0;
    while (c < nwin*G) begin
      if (wave[c]) begin
        st = c; len = 0;
        while (c < NW*G && wave[c]) begin len++; c++; end
        e = st + 2 + D;
        if (len >= D && e / G < nwin && exp_cnt[e / G] < 255) exp_cnt[e / G]++;
      end else begin
        c++;
      end
    end
    run = 0;
    for (int w = 0; w < nwin; w++) begin
      if (exp_cnt[w] == 0 && cmdw[w] != 0) run = (run < S) ? run + 1 : S;
      else run = 0;
      exp_stall[w] = (run == S) ? 1 : 0;
    end
  endtask

  task automatic drive();
    tach_in   = (cyc < NW*G) ? wave[cyc] : 1'b0;
    cmd_speed = (cyc / G < NW) ? 8'(cmdw[cyc / G]) : 8'd0;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    drive();
  endtask

  // Releases reset, plays the waveform and checks every cycle up to stop_cyc.
  task automatic run(input int stop_cyc, input bit use_tbl);
    int k, m;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    cyc   = 0;
    drive();
    forever begin
      if (cyc >= G + 9 && (cyc - 9) % G == 0) begin
        k = (cyc - 9) / G - 1;
        m = (exp_cnt[k] > 199) ? 199 : exp_cnt[k];
        check("speed_valid_pub", int'(speed_valid), 1);
        check("meas_speed", int'(meas_speed), m);
        check("speed1", int'(speed1), m / 100);
        check("speed2", int'(speed2), (m / 10) % 10);
        check("speed3", int'(speed3), m % 10);
        check("overspeed", int'(overspeed), (exp_cnt[k] > 199) ? 1 : 0);
        check("stall", int'(stall), exp_stall[k]);
        if (use_tbl && k < NW - 1) begin
          check("tbl_meas", int'(meas_speed), tbl[k].e_meas);
          check("tbl_digits", int'({speed1, speed2, speed3}),
                (tbl[k].e_d1 << 8) | (tbl[k].e_d2 << 4) | tbl[k].e_d3);
          check("tbl_over", int'(overspeed), tbl[k].e_over);
          check("tbl_stall", int'(stall), tbl[k].e_stall);
        end
      end else begin
        check("speed_valid_idle", int'(speed_valid), 0);
      end
      if (cyc >= stop_cyc) break;
      step();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_meas"}, int'(meas_speed), 0);
    check({tag, "_digits"}, int'({speed1, speed2, speed3}), 0);
    check({tag, "_valid"}, int'(speed_valid), 0);
    check({tag, "_over"}, int'(overspeed), 0);
    check({tag, "_stall"}, int'(stall), 0);
  endtask

  initial begin
    int p, c, hi, lo;
    int mode[NWR];

    //              kind  n    hi lo off   cmd meas d1 d2 d3 ov st
    tbl[0]  = '{1, 123, 4, 4, 0,    0, 123, 1, 2, 3, 0, 0};
    tbl[1]  = '{1, 250, 4, 4, 0,    0, 199, 1, 9, 9, 1, 0};
    tbl[2]  = '{1,  50, 4, 4, 0,    0,  50, 0, 5, 0, 0, 0};
    tbl[3]  = '{2,   0, 0, 0, 0,    0,  60, 0, 6, 0, 0, 0};
    tbl[4]  = '{0,   0, 0, 0, 0,   50,   0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0,   0, 0, 0, 0,   50,   0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0,   0, 0, 0, 0,   50,   0, 0, 0, 0, 0, 1};
    tbl[7]  = '{3,   0, 0, 0, 100, 50,   1, 0, 0, 1, 0, 0};
    tbl[8]  = '{3,   0, 0, 0, G-1,  0,   1, 0, 0, 1, 0, 0};
    tbl[9]  = '{0,   0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0};
    tbl[10] = '{3,   0, 0, 0, 0,    0,   1, 0, 0, 1, 0, 0};
    tbl[11] = '{1,  80, 5, 5, 0,    0,   0, 0, 0, 0, 0, 0};

    clear_wave();
    for (int w = 0; w < NW; w++) begin
      p = w*G + 10;
      cmdw[w] = tbl[w].cmd;
      case (tbl[w].kind)
        1: for (int i = 0; i < tbl[w].n; i++) begin
             put_high(p, tbl[w].hi);
             p += tbl[w].hi + tbl[w].lo;
           end
        2: begin
             for (int i = 0; i < 50; i++) begin
               put_high(p, 4); p += 8;
               put_high(p, 2); p += 6;
             end
             for (int i = 0; i < 10; i++) begin put_high(p, 3); p += 8; end
             for (int i = 0; i < 10; i++) begin put_high(p, 6); p += 11; end
           end
        3: put_high(w*G + tbl[w].off - 2 - D, 5);
        default: ;
      endcase
    end
    model(NW);

    cyc = 0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_zero("reset");

    // Stops mid-conversion of the last window, then resets.
    run(NW*G + 4, 1'b1);
    check("hold_meas", int'(meas_speed), 1);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge CLOCK_50);
    #1;
    check_zero("reset_next");
    repeat (4) @(posedge CLOCK_50);

    clear_wave();
    for (int w = 0; w < NWR; w++) begin
      mode[w] = $urandom_range(0, 2);
      cmdw[w] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 199) : 0;
    end
    c = 0;
    while (c < NWR*G) begin
      if (mode[c / G] == 0) begin
        c++;
      end else begin
        if (mode[c / G] == 1) begin
          hi = $urandom_range(D, D + 1);
          lo = $urandom_range(D, D + 1);
        end else begin
          hi = $urandom_range(1, 8);
          lo = $urandom_range(D, 30);
        end
        put_high(c, hi);
        c += hi + lo;
      end
    end
    for (int i = NWR*G; i < NW*G; i++) wave[i] = 1'b0;
    model(NWR);
    run(NWR*G + 12, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
